// File: rtl/adc_sequencer.sv
// SAR ADC timing master: one-hot phase strobes, serial result capture,
// and a valid/ready result port with sticky overrun.
module adc_sequencer #(
  parameter int NMAX        = 16,
  parameter int SAMP_CYCLES = 4,
  parameter int COMP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cont,
  input  logic [4:0]      cfg_ncycles,
  input  logic            clr_overrun,
  input  logic            comp_out,
  output logic            seq_init,
  output logic            seq_samp,
  output logic            seq_comp,
  output logic            seq_update,
  output logic            busy,
  output logic [NMAX-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            overrun
);

  localparam int CW = 8;

  // One-hot so each strobe is a bare flop output feeding the clock gate.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_INIT = 5'b00010,
    S_SAMP = 5'b00100,
    S_COMP = 5'b01000,
    S_UPD  = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [4:0]      bit_q, bit_d;
  logic [4:0]      n_q, n_d;
  logic [NMAX-1:0] shift_q, shift_d;
  logic [NMAX-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            eoc;
  logic            xfer;

  function automatic logic [4:0] clamp(input logic [4:0] c);
    if (c == 5'd0) return 5'd1;
    if (32'(c) > NMAX) return 5'(NMAX);
    return c;
  endfunction

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      n_q      <= '0;
      shift_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      n_q      <= n_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Phase sequencing, decision capture and result handoff.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    n_d      = n_q;
    shift_d  = shift_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    eoc      = 1'b0;
    xfer     = valid_q & result_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          n_d     = clamp(cfg_ncycles);
          shift_d = '0;
        end
      end
      S_INIT: begin
        state_d = S_SAMP;
        cyc_d   = '0;
      end
      S_SAMP: begin
        if (cyc_q == CW'(SAMP_CYCLES - 1)) begin
          state_d = S_COMP;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_COMP: begin
        if (cyc_q == CW'(COMP_CYCLES - 1)) begin
          state_d = S_UPD;
          cyc_d   = '0;
          shift_d = {shift_q[NMAX-2:0], comp_out};
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_UPD: begin
        bit_d = bit_q + 5'd1;
        cyc_d = '0;
        if (bit_d < n_q) begin
          state_d = S_COMP;
        end else begin
          eoc = 1'b1;
          if (cont) begin
            state_d = S_INIT;
            n_d     = clamp(cfg_ncycles);
            shift_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (eoc) begin
      result_d = shift_q;
      valid_d  = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // A fresh overrun outranks a simultaneous clear.
    if (clr_overrun) ovr_d = 1'b0;
    if (eoc && valid_q && !xfer) ovr_d = 1'b1;
  end

  assign seq_init     = state_q[1];
  assign seq_samp     = state_q[2];
  assign seq_comp     = state_q[3];
  assign seq_update   = state_q[4];
  assign busy         = ~state_q[0];
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: directed scenarios plus random traffic,
// checked against a phase-schedule reference model.
module tb_adc_sequencer;

  localparam int NMAX = 16;
  localparam int S    = 4;
  localparam int C    = 2;

  localparam int P_IDLE = 0;
  localparam int P_INIT = 1;
  localparam int P_SAMP = 2;
  localparam int P_COMP = 3;
  localparam int P_UPD  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cont;
  logic [4:0]      cfg_ncycles;
  logic            clr_overrun;
  logic            comp_out;
  logic            seq_init;
  logic            seq_samp;
  logic            seq_comp;
  logic            seq_update;
  logic            busy;
  logic [NMAX-1:0] result;
  logic            result_valid;
  logic            result_ready;
  logic            overrun;

  int ntests = 0;
  int nfail  = 0;

  int        q[$];
  logic [15:0] mword;
  logic [15:0] mres;
  bit        mvalid;
  bit        movr;
  int        mn;
  int        mk;
  int        nconv;
  int        ninit;
  bit        pat_en;
  logic [15:0] pat;
  bit        ready_at_eoc;

  always #5 clk = ~clk;

  adc_sequencer #(
    .NMAX(NMAX), .SAMP_CYCLES(S), .COMP_CYCLES(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cont(cont),
    .cfg_ncycles(cfg_ncycles),
    .clr_overrun(clr_overrun),
    .comp_out(comp_out),
    .seq_init(seq_init),
    .seq_samp(seq_samp),
    .seq_comp(seq_comp),
    .seq_update(seq_update),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun(overrun)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes(int p);
    case (p)
      P_INIT:  return 4'b1000;
      P_SAMP:  return 4'b0100;
      P_COMP:  return 4'b0010;
      P_UPD:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Lay out the whole phase schedule of one conversion.
  task automatic build(int cfg);
    mn = (cfg == 0) ? 1 : (cfg > NMAX) ? NMAX : cfg;
    q.delete();
    q.push_back(P_INIT);
    repeat (S) q.push_back(P_SAMP);
    for (int i = 0; i < mn; i++) begin
      repeat (C) q.push_back(P_COMP);
      q.push_back(P_UPD);
    end
    mword = '0;
    mk    = 0;
  endtask

  task automatic model_reset();
    q.delete();
    mvalid = 0;
    movr   = 0;
    mres   = '0;
    mword  = '0;
    mk     = 0;
  endtask

  task automatic check();
    int cur;
    logic [3:0] sv;
    cur = (q.size() != 0) ? q[0] : P_IDLE;
    sv  = {seq_init, seq_samp, seq_comp, seq_update};
    chk("strobes", 32'(sv), 32'(strobes(cur)));
    chk("onehot", 32'($countones(sv) <= 1), 32'd1);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("valid", 32'(result_valid), 32'(mvalid));
    chk("result", 32'(result), 32'(mres));
    chk("overrun", 32'(overrun), 32'(movr));
    if (seq_init) ninit++;
  endtask

  task automatic drive_comp();
    if (pat_en) comp_out = (mn > mk) ? pat[mn-1-mk] : 1'b0;
    else comp_out = 1'($urandom);
    if (ready_at_eoc)
      result_ready = (q.size() == 1 && q[0] == P_UPD);
  endtask

  // Advance the model over one clock edge, then compare.
  task automatic tick();
    int cur;
    bit lastc, eoc, xfer;
    cur   = (q.size() != 0) ? q[0] : P_IDLE;
    lastc = (cur == P_COMP) && q.size() > 1 && q[1] == P_UPD;
    eoc   = (cur == P_UPD) && q.size() == 1;
    xfer  = mvalid && result_ready;
    if (lastc) begin
      mword = {mword[14:0], comp_out};
      mk++;
    end
    if (clr_overrun) movr = 0;
    if (eoc) begin
      if (mvalid && !xfer) movr = 1;
      mres   = mword;
      mvalid = 1;
      nconv++;
    end else if (xfer) begin
      mvalid = 0;
    end
    if (q.size() != 0) void'(q.pop_front());
    if (eoc && cont) build(int'(cfg_ncycles));
    else if (cur == P_IDLE && start) build(int'(cfg_ncycles));
    @(posedge clk);
    #1;
    check();
    drive_comp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check();
  endtask

  task automatic wait_conv(int target);
    int b = 0;
    while (nconv < target && b < 500) begin
      tick();
      b++;
    end
    chk("conv_timeout", 32'(nconv >= target), 32'd1);
  endtask

  task automatic run_one(int cfg, logic [15:0] p, int exp_lat,
                         logic [15:0] exp_res, string tag);
    int lat = 0;
    pat_en       = 1;
    pat          = p;
    result_ready = 1'b1;
    cfg_ncycles  = 5'(cfg);
    start        = 1'b1;
    tick();
    start = 1'b0;
    while (!result_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    tick();
    tick();
    pat_en = 0;
  endtask

  initial begin
    int i0;
    int c0;
    rst          = 1'b1;
    start        = 1'b0;
    cont         = 1'b0;
    cfg_ncycles  = 5'd16;
    clr_overrun  = 1'b0;
    comp_out     = 1'b0;
    result_ready = 1'b0;
    pat_en       = 0;
    pat          = '0;
    ready_at_eoc = 0;
    nconv        = 0;
    ninit        = 0;
    mn           = 1;
    model_reset();
    @(posedge clk);
    #1;
    check();
    rst = 1'b0;
    tick();

    // Reset during the second sampling cycle.
    cfg_ncycles = 5'd16;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("samp2", 32'(seq_samp), 32'd1);
    do_reset();
    chk("rst_samp", 32'(seq_samp), 32'd0);
    repeat (3) tick();
    chk("rst_novalid", 32'(result_valid), 32'd0);

    // Full-length, clamp-low and clamp-high conversions.
    run_one(16, 16'hAAAA, 53, 16'hAAAA, "n16");
    run_one(0, 16'hFFFF, 8, 16'h0001, "n0");
    run_one(20, 16'hFFFF, 53, 16'hFFFF, "n20");

    // Continuous mode, nobody consuming: overrun.
    result_ready = 1'b0;
    cont         = 1'b1;
    cfg_ncycles  = 5'd2;
    c0           = nconv;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_conv(c0 + 2);
    chk("ovr_after2", 32'(overrun), 32'd1);
    cont = 1'b0;
    wait_conv(c0 + 3);
    chk("cont_idle", 32'(busy), 32'd0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();

    // Accept word 1 on the very edge word 2 loads.
    cont        = 1'b1;
    cfg_ncycles = 5'd1;
    c0          = nconv;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_conv(c0 + 1);
    ready_at_eoc = 1;
    wait_conv(c0 + 2);
    ready_at_eoc = 0;
    chk("sim_valid", 32'(result_valid), 32'd1);
    chk("sim_ovr", 32'(overrun), 32'd0);
    cont         = 1'b0;
    result_ready = 1'b0;
    wait_conv(c0 + 3);
    result_ready = 1'b1;
    repeat (3) tick();

    // Start pulse while busy is ignored.
    cfg_ncycles = 5'd3;
    i0          = ninit;
    c0          = nconv;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && !seq_comp; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_conv(c0 + 1);
    repeat (4) tick();
    chk("busy_init_cnt", 32'(ninit - i0), 32'd1);
    chk("busy_conv_cnt", 32'(nconv - c0), 32'd1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      start        = ($urandom % 8) == 0;
      cont         = ($urandom % 4) == 0;
      cfg_ncycles  = 5'($urandom % 32);
      result_ready = ($urandom % 3) == 0;
      clr_overrun  = ($urandom % 16) == 0;
      if ($urandom % 500 == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Digital timing master and result receiver for the SAR ADC core.
- Generates the one-hot phase strobes `seq_init`, `seq_samp`, `seq_comp` and `seq_update` that feed the ADC clock gate.
- Captures the serial comparator decision stream from `comp_out`, MSB first, and assembles each conversion into a parallel word.
- Presents each word on a valid/ready output interface. Sits between the chip-level control/readout logic and the ADC macro.

Parameters:
- NMAX, 16, maximum comparisons per conversion; sets `result` width.
- SAMP_CYCLES, 4, clk cycles `seq_samp` is held high (≥1).
- COMP_CYCLES, 2, clk cycles `seq_comp` is held high per decision (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one conversion; sampled only in IDLE.
- cont  input  1  continuous mode; when high at end of conversion, the next conversion begins with no idle cycle.
- cfg_ncycles  input  5  comparisons per conversion; latched at conversion start.
- clr_overrun  input  1  clears `overrun`.
- comp_out  input  1  comparator decision from the ADC.
- seq_init  output  1  init phase strobe.
- seq_samp  output  1  sampling phase strobe.
- seq_comp  output  1  comparator phase strobe.
- seq_update  output  1  SAR update phase strobe.
- busy  output  1  conversion in progress.
- result  output  NMAX  last completed conversion, right-aligned.
- result_valid  output  1  `result` holds an unconsumed word.
- result_ready  input  1  consumer accepts `result`.
- overrun  output  1  sticky: a completed word overwrote an unconsumed one.

Behaviour:
- Reset: state IDLE; all `seq_*`, `busy`, `result_valid` and `overrun` are 0; `result` is 0; counters and shift register cleared. Reset mid-conversion aborts immediately, with no partial result.
- `seq_*` outputs are driven directly from flops (they feed clock gates): glitch-free and at most one high in any cycle.
- State machine: IDLE → INIT → SAMP → COMP → UPDATE → (COMP or END).
  - IDLE: `start`=1 at an edge → INIT. At the same edge, latch `cfg_ncycles` into an internal count `n`, clamped to 1 if 0 and to NMAX if >NMAX. Clear the shift register and set `busy`=1.
  - INIT: 1 cycle, `seq_init`=1.
  - SAMP: SAMP_CYCLES cycles, `seq_samp`=1.
  - COMP: COMP_CYCLES cycles, `seq_comp`=1. `comp_out` is sampled at the edge ending the last COMP cycle: `shift = {shift[NMAX-2:0], comp_out}`.
  - UPDATE: 1 cycle, `seq_update`=1. Bit counter increments. If count < `n` → COMP; else end of conversion.
- End of conversion, at the edge ending the final UPDATE:
  - `result` ← shift register. The `n` bits sit in the low positions; upper bits are 0.
  - `result_valid` ← 1.
  - If `result_valid` was already 1 and no handshake occurs at that edge, set `overrun`=1 and overwrite `result`.
  - If `cont`=1 → INIT at the same edge, `busy` stays 1. Otherwise → IDLE, `busy` ← 0.
- Latency: start edge to `result_valid` is 1 + SAMP_CYCLES + n·(COMP_CYCLES+1) cycles. With defaults and n=16, that is 53.
- Handshake: transfer occurs at an edge where `result_valid` and `result_ready` are both 1; `result_valid` then clears. If a new result loads at the same edge as a transfer, `result_valid` stays 1 with the new word and there is no overrun. `result` is stable while `result_valid`=1 and no transfer occurs.
- `start` while `busy` is ignored. `cont` is sampled only at end of conversion.
- `clr_overrun` clears `overrun` at the next edge. If it coincides with a new overrun event, the set wins.
- `result_ready` has no effect on sequencing; conversions never stall.

Test Plan:
- Reset mid-SAMP: assert `rst` during the 2nd `seq_samp` cycle → all outputs 0 immediately, IDLE after release, no `result_valid`.
- Single conversion: `cfg_ncycles`=16, `comp_out` pattern 1010…10, `result_ready`=1 → `seq_init` 1 cycle, `seq_samp` 4, then 16×(2 `seq_comp` + 1 `seq_update`); `result`=16'hAAAA with `result_valid` 53 cycles after start; strobes one-hot in every cycle.
- Short conversion with clamping: `cfg_ncycles`=0, `comp_out`=1 → exactly 1 decision, `result`=16'h0001, latency 8. Then `cfg_ncycles`=20 with `comp_out`=1 → 16 decisions, `result`=16'hFFFF.
- Continuous mode with overrun: `cont`=1, `result_ready`=0, 3 conversions → `seq_init` immediately follows each final `seq_update`; `busy` never drops; `overrun`=1 after the 2nd conversion; `result` is the 3rd word; `clr_overrun` clears the flag.
- Simultaneous load and accept: `result_ready` pulsed exactly at the end-of-conversion edge of conversion 2 while word 1 is pending → `result_valid` stays 1 with word 2, `overrun`=0.
- `start` ignored while busy: pulse `start` during COMP → no extra `seq_init` and the conversion count is unchanged.
